sd_cmd_engine: RTL

- Parametrised SD/SDIO command-line engine: serialises a 48-bit host command with hardware-computed CRC7 onto a tristated CMD line, then optionally captures a 48-bit or 136-bit card response with timeout, end-bit and CRC7 checking.
- Generates its own SD clock from the system clock via a divider.
- Sits between the card-init / data-transfer controller (command handshake) and the top-level CMD pad (oe/o/i split, tristate at top).

---
 rtl/sd_cmd_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_engine.sv
// SD/SDIO CMD-line engine: sends a 48-bit command with serial CRC7 on a split
// tristate pad and optionally captures an R48/R136 response with checks.
module sd_cmd_engine #(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 64,
    parameter int NCC          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic         crc_err,
    output logic [135:0] resp_data,
    output logic         sd_clk,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    input  logic         sd_cmd_i
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] NCC_LAST = 16'(NCC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_RECV, S_CHECK, S_GAP
    } state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    // Clock divider; ticks mark the clk edge on which sd_clk changes level.
    logic [15:0] div_q;
    logic        sd_clk_q;
    logic        div_term, fall_tick, rise_tick;

    assign div_term  = (div_q == DIV_LAST);
    assign fall_tick = div_term & sd_clk_q;
    assign rise_tick = div_term & ~sd_clk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            sd_clk_q <= 1'b0;
        end else if (div_term) begin
            div_q    <= '0;
            sd_clk_q <= ~sd_clk_q;
        end else begin
            div_q    <= div_q + 16'd1;
        end
    end

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [39:0]    shreg_q, shreg_d;
    logic [6:0]     crc_q, crc_d;
    logic [135:0]   resp_q, resp_d;
    logic [1:0]     rtype_q, rtype_d;
    logic           o_q, o_d, oe_q, oe_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           timeout_q, timeout_d, crc_err_q, crc_err_d;
    logic [15:0]    rx_last;

    assign rx_last = (rtype_q == 2'd3) ? 16'd135 : 16'd47;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            crc_q     <= '0;
            resp_q    <= '0;
            rtype_q   <= '0;
            o_q       <= 1'b1;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            crc_q     <= crc_d;
            resp_q    <= resp_d;
            rtype_q   <= rtype_d;
            o_q       <= o_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            crc_err_q <= crc_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        crc_d     = crc_q;
        resp_d    = resp_q;
        rtype_d   = rtype_q;
        o_d       = o_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        crc_err_d = crc_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    shreg_d   = {2'b01, cmd_index, cmd_arg};
                    crc_d     = '0;
                    rtype_d   = resp_type;
                    resp_d    = '0;
                    timeout_d = 1'b0;
                    crc_err_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                // cnt counts bits already driven; the 49th fall ends the end bit.
                if (fall_tick) begin
                    if (cnt_q == 16'd48) begin
                        cnt_d   = '0;
                        o_d     = 1'b1;
                        oe_d    = (rtype_q == 2'd0);
                        state_d = (rtype_q == 2'd0) ? S_GAP : S_WAIT;
                    end else begin
                        oe_d  = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q < 16'd40) begin
                            o_d     = shreg_q[39];
                            shreg_d = {shreg_q[38:0], 1'b0};
                            crc_d   = crc7_step(crc_q, shreg_q[39]);
                        end else if (cnt_q < 16'd47) begin
                            o_d   = crc_q[6];
                            crc_d = {crc_q[5:0], 1'b0};
                        end else begin
                            o_d   = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (rise_tick) begin
                    if (!sd_cmd_i) begin
                        resp_d  = {resp_q[134:0], 1'b0};
                        cnt_d   = 16'd1;
                        state_d = S_RECV;
                    end else if (cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_RECV: begin
                if (rise_tick) begin
                    resp_d = {resp_q[134:0], sd_cmd_i};
                    if (cnt_q == rx_last) begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_CHECK: begin
                if (rtype_q == 2'd1)
                    crc_err_d = (crc7_40(resp_q[47:8]) != resp_q[7:1]) | ~resp_q[0];
                else
                    crc_err_d = ~resp_q[0];
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (fall_tick) begin
                    if (cnt_q == NCC_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        oe_d    = 1'b0;
                        o_d     = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign crc_err   = crc_err_q;
    assign resp_data = resp_q;
    assign sd_clk    = sd_clk_q;
    assign sd_cmd_o  = o_q;
    assign sd_cmd_oe = oe_q;

endmodule
